// File: rtl/scpad_body_responder.sv
// rtl/scpad_body_responder.sv - scratchpad body responder: rotates requests onto SRAM banks and returns responses.
// Optional build macro SCPAD_ZERO_MASKED_EN forces read lanes with a clear mask bit to zero.
module scpad_body_responder #(
  parameter int NUM_BANKS = 32,
  parameter int ELEM_W    = 16,
  parameter int ROW_W     = 10,
  parameter int SRAM_LAT  = 2,
  parameter int ID_W      = 4,
  parameter int SH_W      = $clog2(NUM_BANKS)
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         req_valid,
  input  logic                         req_write,
  input  logic [ID_W-1:0]              req_id,
  input  logic [NUM_BANKS-1:0]         req_valid_mask,
  input  logic [SH_W-1:0]              req_shift,
  input  logic [NUM_BANKS*ROW_W-1:0]   req_slot,
  input  logic [NUM_BANKS*ELEM_W-1:0]  req_wdata,
  output logic                         fe_stall,
  output logic [NUM_BANKS-1:0]         sram_en,
  output logic                         sram_we,
  output logic [NUM_BANKS*ROW_W-1:0]   sram_addr,
  output logic [NUM_BANKS*ELEM_W-1:0]  sram_wdata,
  input  logic [NUM_BANKS*ELEM_W-1:0]  sram_rdata,
  output logic                         res_valid,
  output logic                         res_write,
  output logic [ID_W-1:0]              res_id,
  output logic [NUM_BANKS-1:0]         res_mask,
  output logic [NUM_BANKS*ELEM_W-1:0]  res_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SRAM_LAT - 1);

  logic [1:0]                        state;
  logic [CNT_W-1:0]                  cnt;
  logic                              write_q;
  logic [ID_W-1:0]                   id_q;
  logic [NUM_BANKS-1:0]              mask_q;
  logic [SH_W-1:0]                   shift_q;
  logic [NUM_BANKS*ROW_W-1:0]        slot_q;
  logic [NUM_BANKS*ELEM_W-1:0]       wdata_q;
  logic [NUM_BANKS*ELEM_W-1:0]       rdata_q;

  logic [NUM_BANKS-1:0][ELEM_W-1:0]  wdata_lane;
  logic [NUM_BANKS-1:0][ELEM_W-1:0]  wdata_bank;
  logic [NUM_BANKS-1:0][ELEM_W-1:0]  rdata_bank;
  logic [NUM_BANKS-1:0][ELEM_W-1:0]  rdata_lane;
  logic [NUM_BANKS-1:0]              en_bank;

  assign wdata_lane = wdata_q;
  assign rdata_bank = sram_rdata;

  // Bank b is fed by lane (b - shift); lane i reads back from bank (i + shift).
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_rot
    localparam logic [SH_W-1:0] IDX = SH_W'(g);
    logic [SH_W-1:0] src_lane;
    logic [SH_W-1:0] dst_bank;
    assign src_lane      = IDX - shift_q;
    assign dst_bank      = IDX + shift_q;
    assign en_bank[g]    = mask_q[src_lane];
    assign wdata_bank[g] = wdata_lane[src_lane];
`ifdef SCPAD_ZERO_MASKED_EN
    assign rdata_lane[g] = mask_q[g] ? rdata_bank[dst_bank] : '0;
`else
    assign rdata_lane[g] = rdata_bank[dst_bank];
`endif
  end

  assign fe_stall   = (state == S_ISSUE) || (state == S_WAIT);
  assign sram_en    = (state == S_ISSUE) ? en_bank : '0;
  assign sram_we    = (state == S_ISSUE) && write_q;
  assign sram_addr  = slot_q;
  assign sram_wdata = wdata_bank;
  assign res_valid  = (state == S_RESP);
  assign res_write  = write_q;
  assign res_id     = id_q;
  assign res_mask   = mask_q;
  assign res_rdata  = rdata_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      id_q    <= '0;
      mask_q  <= '0;
      shift_q <= '0;
      slot_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (req_valid) begin
            write_q <= req_write;
            id_q    <= req_id;
            mask_q  <= req_valid_mask;
            shift_q <= req_shift;
            slot_q  <= req_slot;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            state   <= S_ISSUE;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // Writes and empty reads have no data to wait for.
          if (write_q || (mask_q == '0)) begin
            state <= S_RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rdata_q <= rdata_lane;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scpad_body_responder.sv
// tb/tb_scpad_body_responder.sv - directed self-checking bench for scpad_body_responder with a 2-cycle SRAM model.
module tb_scpad_body_responder;

  localparam int NB = 32;
  localparam int EW = 16;
  localparam int RW = 10;

  logic            clk;
  logic            n_rst;
  logic            req_valid;
  logic            req_write;
  logic [3:0]      req_id;
  logic [NB-1:0]   req_valid_mask;
  logic [4:0]      req_shift;
  logic [NB*RW-1:0] req_slot;
  logic [NB*EW-1:0] req_wdata;
  logic            fe_stall;
  logic [NB-1:0]   sram_en;
  logic            sram_we;
  logic [NB*RW-1:0] sram_addr;
  logic [NB*EW-1:0] sram_wdata;
  logic [NB*EW-1:0] sram_rdata;
  logic            res_valid;
  logic            res_write;
  logic [3:0]      res_id;
  logic [NB-1:0]   res_mask;
  logic [NB*EW-1:0] res_rdata;

  int n_checks = 0;
  int n_errors = 0;

  scpad_body_responder dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_write(req_write), .req_id(req_id),
    .req_valid_mask(req_valid_mask), .req_shift(req_shift),
    .req_slot(req_slot), .req_wdata(req_wdata),
    .fe_stall(fe_stall), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .res_valid(res_valid), .res_write(res_write), .res_id(res_id),
    .res_mask(res_mask), .res_rdata(res_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banked SRAM model: 8 rows per bank, every row preset to 0x0100+bank, rdata two cycles after enable.
  logic [EW-1:0] mem [NB][8];
  logic [NB-1:0][EW-1:0] p1, p2;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < 8; r++)
          mem[b][r] <= 16'h0100 + 16'(b);
      p1 <= '0;
      p2 <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (sram_en[b]) begin
          if (sram_we) mem[b][sram_addr[b*RW +: 3]] <= sram_wdata[b*EW +: EW];
          p1[b] <= sram_we ? 16'hDEAD : mem[b][sram_addr[b*RW +: 3]];
        end else begin
          p1[b] <= 16'hDEAD;
        end
      end
      p2 <= p1;
    end
  end
  assign sram_rdata = p2;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB*RW-1:0] rows(input int r);
    logic [NB*RW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*RW +: RW] = RW'(r);
    return v;
  endfunction

  // Presents one request for a single accept edge; returns in the ISSUE cycle.
  task automatic issue_req(input logic w, input logic [3:0] id, input logic [NB-1:0] m,
                           input logic [4:0] sh, input int row, input logic [NB*EW-1:0] wd);
    req_write = w; req_id = id; req_valid_mask = m; req_shift = sh;
    req_slot = rows(row); req_wdata = wd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Walks forward from the ISSUE cycle (cycle 1) until res_valid, counting stall cycles.
  task automatic wait_resp(output int resp_cyc, output int stalls);
    resp_cyc = -1;
    stalls = 0;
    for (int k = 1; k <= 12; k++) begin
      if (res_valid) begin
        resp_cyc = k;
        break;
      end
      if (fe_stall) stalls++;
      tick();
    end
  endtask

  logic [NB*EW-1:0] exp_v;
  logic [NB*EW-1:0] wd;
  int rc, st, cnt_v;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_id = '0;
    req_valid_mask = '0; req_shift = '0; req_slot = '0; req_wdata = '0;
    repeat (3) tick();
    check("rst_fe_stall", fe_stall, 0);
    check("rst_sram_en", sram_en, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_res", {res_valid, res_write, res_id, res_mask}, 0);
    check("rst_res_rdata", res_rdata, 0);
    n_rst = 1'b1;
    cnt_v = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt_v += int'(fe_stall) + int'(res_valid) + int'(|sram_en);
    end
    check("idle_quiet", cnt_v, 0);

    // Write with wrap-around rotation
    wd = '0;
    wd[0 +: EW] = 16'hAAAA;
    wd[EW +: EW] = 16'hBBBB;
    issue_req(1'b1, 4'd7, 32'h0000_0003, 5'd31, 2, wd);
    exp_v = '0;
    exp_v[31*EW +: EW] = 16'hAAAA;
    exp_v[0 +: EW] = 16'hBBBB;
    check("wr_issue_en", sram_en, 32'h8000_0001);
    check("wr_issue_we", sram_we, 1);
    check("wr_issue_stall", fe_stall, 1);
    check("wr_issue_wdata", sram_wdata, exp_v);
    check("wr_issue_addr", sram_addr, rows(2));
    tick();
    check("wr_resp", {res_valid, res_write, res_id, fe_stall}, {1'b1, 1'b1, 4'd7, 1'b0});
    check("wr_resp_rdata", res_rdata, 0);
    tick();
    check("wr_after", {res_valid, res_id, sram_we}, {1'b0, 4'd7, 1'b0});

    // Read latency with shift 1, all lanes
    issue_req(1'b0, 4'd2, '1, 5'd1, 5, '0);
    wait_resp(rc, st);
    check("rd_latency", rc, 4);
    check("rd_stall_cycles", st, 3);
    for (int i = 0; i < NB; i++) exp_v[i*EW +: EW] = 16'h0100 + 16'((i + 1) % NB);
    check("rd_data", res_rdata, exp_v);
    check("rd_id_mask", {res_write, res_id, res_mask}, {1'b0, 4'd2, 32'hFFFF_FFFF});

    // Read back the rotated write
    tick();
    issue_req(1'b0, 4'd9, 32'h0000_0003, 5'd31, 2, '0);
    wait_resp(rc, st);
    check("rb_latency", rc, 4);
    check("rb_data", res_rdata[31:0], 32'hBBBB_AAAA);

    // Back-to-back: request held valid across the first RESP
    tick();
    req_write = 1'b1; req_id = 4'd3; req_valid_mask = 32'h1; req_shift = '0;
    req_slot = rows(1); req_wdata = '0; req_valid = 1'b1;
    tick();
    req_id = 4'd4;
    tick();
    check("b2b_first", {res_valid, res_id}, {1'b1, 4'd3});
    tick();
    req_valid = 1'b0;
    check("b2b_second_issue", {fe_stall, res_valid}, {1'b1, 1'b0});
    tick();
    check("b2b_second", {res_valid, res_id}, {1'b1, 4'd4});
    cnt_v = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt_v += int'(res_valid);
    end
    check("b2b_no_dup", cnt_v, 0);

    // Zero-mask read
    issue_req(1'b0, 4'd5, '0, 5'd3, 4, '0);
    check("zm_issue_en", sram_en, 0);
    tick();
    check("zm_resp", {res_valid, res_id}, {1'b1, 4'd5});
    check("zm_rdata", res_rdata, 0);
    tick();

    // Asynchronous reset while waiting on read data
    issue_req(1'b0, 4'd6, '1, 5'd0, 0, '0);
    tick();
    check("ar_in_wait", fe_stall, 1);
    #2 n_rst = 1'b0;
    #1;
    check("ar_outputs", {fe_stall, sram_en, sram_we, res_valid, res_write, res_id, res_mask}, 0);
    check("ar_addr_rdata", {sram_addr, res_rdata}, 0);
    tick();
    n_rst = 1'b1;
    cnt_v = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cnt_v += int'(res_valid) + int'(fe_stall);
    end
    check("ar_no_resp", cnt_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
